tlc_count_timer: RTL and testbench

TLC_COUNT_TIMER -- requirements
Module: tlc_count_timer

---
 rtl/tlc_count_timer.sv | 130 +++++++++++++
 tb/tb_tlc_count_timer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tlc_count_timer.sv
// Elapsed-time counter for the traffic-light controller: a cycle count, a
// prescaled seconds count, a target-match pulse and a saturation flag.
module tlc_count_timer #(
  parameter int unsigned CYCLES_PER_SEC = 50000000,
  parameter int unsigned WIDTH          = 31
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             RstCount,
  input  logic             Enable,
  input  logic [WIDTH-1:0] Target,
  input  logic             TargetLoad,
  output logic [WIDTH-1:0] Count,
  output logic [5:0]       Seconds,
  output logic             TickSec,
  output logic             Match,
  output logic             Overflow,
  output logic [1:0]       TmrState
);

  localparam int unsigned      PW         = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
  localparam logic [PW-1:0]    PRESC_MAX  = PW'(CYCLES_PER_SEC - 1);
  localparam logic [WIDTH-1:0] COUNT_MAX  = '1;
  localparam logic [5:0]       SEC_MAX    = 6'd63;

  typedef enum logic [1:0] {
    ST_CLR  = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10,
    ST_SAT  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [5:0]       sec_q, sec_d;
  logic             tick_q, tick_d;
  logic             match_q, match_d;
  logic             ovf_q, ovf_d;
  logic             armed_q, armed_d;
  logic             match_fire_s;

  // Next-state logic: RstCount beats saturation, which beats Enable.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    presc_d  = presc_q;
    sec_d    = sec_q;
    tick_d   = 1'b0;
    ovf_d    = ovf_q;
    armed_d  = armed_q;

    // A match is only raised while the timer is actually allowed to count.
    match_fire_s = armed_q && (count_q == target_q) && Enable && (state_q != ST_SAT);
    match_d      = match_fire_s;
    if (match_fire_s) begin
      armed_d = 1'b0;
    end else begin
      armed_d = armed_q;
    end

    if (TargetLoad) begin
      target_d = Target;
      armed_d  = 1'b1;
    end else begin
      target_d = target_q;
    end

    if (RstCount) begin
      state_d = ST_CLR;
      count_d = '0;
      presc_d = '0;
      sec_d   = 6'd0;
      ovf_d   = 1'b0;
      armed_d = 1'b1;
    end else if (state_q == ST_SAT) begin
      state_d = ST_SAT;
    end else if (Enable && (count_q == COUNT_MAX)) begin
      state_d = ST_SAT;
      ovf_d   = 1'b1;
    end else if (Enable) begin
      state_d = ST_RUN;
      count_d = count_q + WIDTH'(1);
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        tick_d  = 1'b1;
        sec_d   = (sec_q == SEC_MAX) ? SEC_MAX : (sec_q + 6'd1);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      state_d = ST_HOLD;
    end
  end

  // State and output registers; Rst clears everything including the target.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= ST_CLR;
      count_q  <= '0;
      target_q <= '0;
      presc_q  <= '0;
      sec_q    <= 6'd0;
      tick_q   <= 1'b0;
      match_q  <= 1'b0;
      ovf_q    <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      target_q <= target_d;
      presc_q  <= presc_d;
      sec_q    <= sec_d;
      tick_q   <= tick_d;
      match_q  <= match_d;
      ovf_q    <= ovf_d;
      armed_q  <= armed_d;
    end
  end

  assign Count    = count_q;
  assign Seconds  = sec_q;
  assign TickSec  = tick_q;
  assign Match    = match_q;
  assign Overflow = ovf_q;
  assign TmrState = state_q;

endmodule

// File: tb/tb_tlc_count_timer.sv
// Scoreboard bench for tlc_count_timer with CYCLES_PER_SEC=4, WIDTH=8.
module tb_tlc_count_timer;

  localparam logic [1:0] S_CLR  = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HOLD = 2'b10;
  localparam logic [1:0] S_SAT  = 2'b11;

  typedef struct packed {
    logic [7:0] cnt;
    logic [5:0] sec;
    logic       tk;
    logic       mt;
    logic       ov;
    logic [1:0] st;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rst_count;
  logic       enable;
  logic [7:0] target;
  logic       target_load;
  logic [7:0] count;
  logic [5:0] seconds;
  logic       tick_sec;
  logic       match;
  logic       overflow;
  logic [1:0] tmr_state;

  int   total;
  int   bad;
  exp_t sb_q[$];
  exp_t e;

  tlc_count_timer #(.CYCLES_PER_SEC(4), .WIDTH(8)) dut (
    .Clk(clk), .Rst(rst), .RstCount(rst_count), .Enable(enable),
    .Target(target), .TargetLoad(target_load),
    .Count(count), .Seconds(seconds), .TickSec(tick_sec), .Match(match),
    .Overflow(overflow), .TmrState(tmr_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(input int c, input int s, input logic tk, input logic mt,
                              input logic ov, input logic [1:0] st);
    exp_t r;
    r.cnt = 8'(c);
    r.sec = 6'(s);
    r.tk  = tk;
    r.mt  = mt;
    r.ov  = ov;
    r.st  = st;
    return r;
  endfunction

  // Drive one cycle of inputs, then sample just after the active edge.
  task automatic cyc(input logic rc, input logic en, input logic tl, input logic [7:0] tg);
    rst_count   = rc;
    enable      = en;
    target_load = tl;
    target      = tg;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; rst_count = 1'b0; target_load = 1'b0; target = 8'd0;
    #2 rst = 1'b0;
    #1;
    total++;
    if ({count, seconds, tick_sec, match, overflow, tmr_state} !== 19'd0) begin
      bad++;
      $display("FAIL reset_async: got cnt=%0d sec=%0d st=%0d, want all zero", count, seconds, tmr_state);
    end
    @(posedge clk);
    #1;
    total++;
    if ({count, seconds, tick_sec, match, overflow, tmr_state} !== 19'd0) begin
      bad++;
      $display("FAIL reset_held: got cnt=%0d sec=%0d st=%0d, want all zero", count, seconds, tmr_state);
    end
    rst = 1'b1;
  endtask

  task automatic test_count();
    for (int k = 1; k <= 10; k++) sb_q.push_back(mk(k, k / 4, (k % 4) == 0, 1'b0, 1'b0, S_RUN));
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'd0);
      e = sb_q.pop_front();
      total++;
      if ({count, seconds, tick_sec, match, overflow, tmr_state} !== e) begin
        bad++;
        $display("FAIL count[%0d]: got cnt=%0d sec=%0d tick=%0b match=%0b ovf=%0b st=%0d, want cnt=%0d sec=%0d tick=%0b match=%0b ovf=%0b st=%0d",
                 k, count, seconds, tick_sec, match, overflow, tmr_state, e.cnt, e.sec, e.tk, e.mt, e.ov, e.st);
      end
    end
  endtask

  task automatic test_hold();
    logic rc[12];
    logic en[12];
    sb_q.push_back(mk(0, 0, 1'b0, 1'b0, 1'b0, S_CLR));
    rc[0] = 1'b1; en[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      sb_q.push_back(mk(k, (k >= 4) ? 1 : 0, k == 4, k == 1, 1'b0, S_RUN));
      rc[k] = 1'b0; en[k] = 1'b1;
    end
    for (int k = 6; k <= 8; k++) begin
      sb_q.push_back(mk(5, 1, 1'b0, 1'b0, 1'b0, S_HOLD));
      rc[k] = 1'b0; en[k] = 1'b0;
    end
    sb_q.push_back(mk(6, 1, 1'b0, 1'b0, 1'b0, S_RUN));
    sb_q.push_back(mk(7, 1, 1'b0, 1'b0, 1'b0, S_RUN));
    sb_q.push_back(mk(8, 2, 1'b1, 1'b0, 1'b0, S_RUN));
    for (int k = 9; k <= 11; k++) begin
      rc[k] = 1'b0; en[k] = 1'b1;
    end
    for (int k = 0; k < 12; k++) begin
      cyc(rc[k], en[k], 1'b0, 8'd0);
      e = sb_q.pop_front();
      total++;
      if ({count, seconds, tick_sec, match, overflow, tmr_state} !== e) begin
        bad++;
        $display("FAIL hold[%0d]: got cnt=%0d sec=%0d tick=%0b match=%0b ovf=%0b st=%0d, want cnt=%0d sec=%0d tick=%0b match=%0b ovf=%0b st=%0d",
                 k, count, seconds, tick_sec, match, overflow, tmr_state, e.cnt, e.sec, e.tk, e.mt, e.ov, e.st);
      end
    end
  endtask

  task automatic test_target();
    sb_q.push_back(mk(0, 0, 1'b0, 1'b0, 1'b0, S_CLR));
    for (int k = 1; k <= 7; k++) sb_q.push_back(mk(k, (k >= 4) ? 1 : 0, k == 4, k == 1, 1'b0, S_RUN));
    sb_q.push_back(mk(0, 0, 1'b0, 1'b0, 1'b0, S_CLR));
    for (int k = 1; k <= 6; k++) sb_q.push_back(mk(k, (k >= 4) ? 1 : 0, k == 4, k == 4, 1'b0, S_RUN));
    for (int k = 0; k < 15; k++) begin
      if (k == 0) cyc(1'b1, 1'b1, 1'b0, 8'd0);
      else if (k == 8) cyc(1'b1, 1'b1, 1'b1, 8'd3);
      else cyc(1'b0, 1'b1, 1'b0, 8'd0);
      e = sb_q.pop_front();
      total++;
      if ({count, seconds, tick_sec, match, overflow, tmr_state} !== e) begin
        bad++;
        $display("FAIL target[%0d]: got cnt=%0d sec=%0d tick=%0b match=%0b ovf=%0b st=%0d, want cnt=%0d sec=%0d tick=%0b match=%0b ovf=%0b st=%0d",
                 k, count, seconds, tick_sec, match, overflow, tmr_state, e.cnt, e.sec, e.tk, e.mt, e.ov, e.st);
      end
    end
  endtask

  task automatic test_saturate();
    int c;
    sb_q.push_back(mk(0, 0, 1'b0, 1'b0, 1'b0, S_CLR));
    for (int k = 1; k <= 260; k++) begin
      c = (k > 255) ? 255 : k;
      sb_q.push_back(mk(c, ((c / 4) > 63) ? 63 : (c / 4), (k <= 255) && ((k % 4) == 0),
                        k == 4, k >= 256, (k >= 256) ? S_SAT : S_RUN));
    end
    sb_q.push_back(mk(255, 63, 1'b0, 1'b0, 1'b1, S_SAT));
    sb_q.push_back(mk(0, 0, 1'b0, 1'b0, 1'b0, S_CLR));
    sb_q.push_back(mk(0, 0, 1'b0, 1'b0, 1'b0, S_HOLD));
    for (int k = 0; k < 264; k++) begin
      if (k == 0) cyc(1'b1, 1'b1, 1'b0, 8'd0);
      else if (k <= 260) cyc(1'b0, 1'b1, 1'b0, 8'd0);
      else if (k == 262) cyc(1'b1, 1'b0, 1'b0, 8'd0);
      else cyc(1'b0, 1'b0, 1'b0, 8'd0);
      e = sb_q.pop_front();
      total++;
      if ({count, seconds, tick_sec, match, overflow, tmr_state} !== e) begin
        bad++;
        $display("FAIL saturate[%0d]: got cnt=%0d sec=%0d tick=%0b match=%0b ovf=%0b st=%0d, want cnt=%0d sec=%0d tick=%0b match=%0b ovf=%0b st=%0d",
                 k, count, seconds, tick_sec, match, overflow, tmr_state, e.cnt, e.sec, e.tk, e.mt, e.ov, e.st);
      end
    end
  endtask

  task automatic test_async_reset();
    cyc(1'b1, 1'b1, 1'b0, 8'd0);
    for (int k = 0; k < 50; k++) cyc(1'b0, 1'b1, 1'b0, 8'd0);
    total++;
    if (count !== 8'd50) begin
      bad++;
      $display("FAIL async_precount: got cnt=%0d, want 50", count);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({count, seconds, tick_sec, match, overflow, tmr_state} !== 19'd0) begin
      bad++;
      $display("FAIL async_immediate: got cnt=%0d sec=%0d ovf=%0b st=%0d, want all zero", count, seconds, overflow, tmr_state);
    end
    @(posedge clk);
    #1;
    total++;
    if ({count, seconds, tick_sec, match, overflow, tmr_state} !== 19'd0) begin
      bad++;
      $display("FAIL async_held: got cnt=%0d st=%0d, want all zero", count, tmr_state);
    end
    rst = 1'b1;
    sb_q.push_back(mk(1, 0, 1'b0, 1'b0, 1'b0, S_RUN));
    sb_q.push_back(mk(2, 0, 1'b0, 1'b0, 1'b0, S_RUN));
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'd0);
      e = sb_q.pop_front();
      total++;
      if ({count, seconds, tick_sec, match, overflow, tmr_state} !== e) begin
        bad++;
        $display("FAIL async_resume[%0d]: got cnt=%0d sec=%0d tick=%0b match=%0b ovf=%0b st=%0d, want cnt=%0d sec=%0d tick=%0b match=%0b ovf=%0b st=%0d",
                 k, count, seconds, tick_sec, match, overflow, tmr_state, e.cnt, e.sec, e.tk, e.mt, e.ov, e.st);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 300; j++) begin
      sb_q.push_back(mk(j % 4, 0, 1'b0, (j % 4) == 1, 1'b0, ((j % 4) == 0) ? S_CLR : S_RUN));
      cyc((j % 4) == 0, 1'b1, 1'b0, 8'd0);
      e = sb_q.pop_front();
      total++;
      if ({count, seconds, tick_sec, match, overflow, tmr_state} !== e) begin
        bad++;
        $display("FAIL back_to_back[%0d]: got cnt=%0d sec=%0d tick=%0b match=%0b ovf=%0b st=%0d, want cnt=%0d sec=%0d tick=%0b match=%0b ovf=%0b st=%0d",
                 j, count, seconds, tick_sec, match, overflow, tmr_state, e.cnt, e.sec, e.tk, e.mt, e.ov, e.st);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_count = 1'b0; enable = 1'b0; target_load = 1'b0; target = 8'd0;
    rst = 1'b1;
    test_reset();
    test_count();
    test_hold();
    test_target();
    test_saturate();
    test_async_reset();
    test_back_to_back();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
